// File: rtl/control_unit_pkg.sv
//------------------------------------------------------------------------------
// control_unit_pkg
// Shared state, opcode and control-field encodings for the multicycle control unit.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_REG   = 2'b10;
    localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

    localparam logic [1:0] c_SRCB_WDATA = 2'b00;
    localparam logic [1:0] c_SRCB_IMM   = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURES = 2'b10;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            c_OP_STORE:  imm_src = c_IMM_S;
            c_OP_BRANCH: imm_src = c_IMM_B;
            c_OP_JAL:    imm_src = c_IMM_J;
            c_OP_LUI:    imm_src = c_IMM_U;
            default:     imm_src = c_IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// alu_decoder
// Maps ALU operation class plus funct3/funct7b5/op[5] onto the ALUControl code.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
    import control_unit_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_ALU_ADD;
        case (i_alu_op)
            c_ALUOP_SUB: o_alu_control = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (i_funct3)
                    // op[5] separates R-type sub from addi sharing funct7b5
                    3'b000:  o_alu_control = (i_funct7b5 && i_op5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  o_alu_control = c_ALU_SLT;
                    3'b110:  o_alu_control = c_ALU_OR;
                    3'b111:  o_alu_control = c_ALU_AND;
                    default: o_alu_control = c_ALU_ADD;
                endcase
            end
            default: o_alu_control = c_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// control_unit
// Moore-style multicycle RISC-V control FSM with sticky illegal-opcode trap.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;
    logic [1:0] w_alu_op;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:            w_next_state = S_EXECR;
                    c_OP_ITYPE:            w_next_state = S_EXECI;
                    c_OP_BRANCH:           w_next_state = S_BRANCH;
                    c_OP_JAL:              w_next_state = S_JAL;
                    c_OP_LUI:              w_next_state = S_LUI;
                    default:               w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // An opcode that drifted away from lw/sw here is treated as illegal
                if (op == c_OP_LOAD)       w_next_state = S_MEMREAD;
                else if (op == c_OP_STORE) w_next_state = S_MEMWRITE;
                else                       w_next_state = S_TRAP;
            end
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_LUI:      w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = c_RES_ALUOUT;
        ALUSrcA    = c_SRCA_PC;
        ALUSrcB    = c_SRCB_WDATA;
        w_alu_op   = c_ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = c_SRCA_REG;
                ALUSrcB = c_SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = c_RES_DATA;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = c_SRCA_REG;
                w_alu_op = c_ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = c_SRCA_REG;
                ALUSrcB  = c_SRCB_IMM;
                w_alu_op = c_ALUOP_FUNCT;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = c_SRCA_REG;
                w_alu_op = c_ALUOP_SUB;
                case (funct3)
                    3'b000:  w_pcwrite = Zero;
                    3'b001:  w_pcwrite = ~Zero;
                    default: w_pcwrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA   = c_SRCA_OLDPC;
                ALUSrcB   = c_SRCB_FOUR;
                w_pcwrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = c_SRCA_ZERO;
                ALUSrcB = c_SRCB_IMM;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

    // Write enables are squashed combinationally so reset aborts in the same cycle
    assign PCWrite  = w_pcwrite  & ~resetn;
    assign MemWrite = w_memwrite & ~resetn;
    assign IRWrite  = w_irwrite  & ~resetn;
    assign RegWrite = w_regwrite & ~resetn;
    assign ImmSrc   = imm_src(op);
    assign state    = r_state;
    assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// tb_control_unit
// Directed self-checking bench for control_unit using immediate assertions.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

    logic       clk;
    logic       resetn;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] state;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .state      (state),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {PCWrite, MemWrite, IRWrite, RegWrite}
    function automatic logic [7:0] en();
        return {4'b0, PCWrite, MemWrite, IRWrite, RegWrite};
    endfunction

    initial begin
        resetn   = 1'b1;
        op       = 7'b0000011;
        funct3   = 3'b010;
        funct7b5 = 1'b0;
        Zero     = 1'b0;

        // Reset
        step();
        chk("rst_state", {4'b0, state}, 8'd0);
        chk("rst_illegal", {7'b0, illegal}, 8'd0);
        chk("rst_en", en(), 8'b0000);
        step();
        resetn = 1'b0;
        #1;

        // lw x1,4(x0): FETCH DECODE MEMADR MEMREAD MEMWB
        chk("lw_c1_state", {4'b0, state}, 8'd0);
        chk("lw_c1_en", en(), 8'b1010);
        chk("lw_c1_srcb", {6'b0, ALUSrcB}, 8'b10);
        chk("lw_c1_res", {6'b0, ResultSrc}, 8'b10);
        chk("lw_c1_adr", {7'b0, AdrSrc}, 8'd0);
        step();
        chk("lw_c2_state", {4'b0, state}, 8'd1);
        chk("lw_c2_en", en(), 8'b0000);
        chk("lw_c2_srca", {6'b0, ALUSrcA}, 8'b01);
        chk("lw_c2_srcb", {6'b0, ALUSrcB}, 8'b01);
        chk("lw_c2_imm", {5'b0, ImmSrc}, 8'b000);
        step();
        chk("lw_c3_state", {4'b0, state}, 8'd2);
        chk("lw_c3_srca", {6'b0, ALUSrcA}, 8'b10);
        chk("lw_c3_en", en(), 8'b0000);
        step();
        chk("lw_c4_state", {4'b0, state}, 8'd3);
        chk("lw_c4_adr", {7'b0, AdrSrc}, 8'd1);
        chk("lw_c4_en", en(), 8'b0000);
        step();
        chk("lw_c5_state", {4'b0, state}, 8'd4);
        chk("lw_c5_en", en(), 8'b0001);
        chk("lw_c5_res", {6'b0, ResultSrc}, 8'b01);
        step();
        chk("lw_done", {4'b0, state}, 8'd0);

        // sw
        op = 7'b0100011;
        step();
        chk("sw_imm", {5'b0, ImmSrc}, 8'b001);
        step();
        chk("sw_c3_en", en(), 8'b0000);
        step();
        chk("sw_c4_state", {4'b0, state}, 8'd5);
        chk("sw_c4_en", en(), 8'b0100);
        chk("sw_c4_adr", {7'b0, AdrSrc}, 8'd1);
        step();
        chk("sw_done", {4'b0, state}, 8'd0);

        // beq / bne, all combinations inside one BRANCH cycle
        op = 7'b1100011;
        funct3 = 3'b000;
        step();
        step();
        chk("br_state", {4'b0, state}, 8'd9);
        chk("br_alu", {5'b0, ALUControl}, 8'b001);
        chk("br_imm", {5'b0, ImmSrc}, 8'b010);
        Zero = 1'b1; #1;
        chk("beq_z1", {7'b0, PCWrite}, 8'd1);
        Zero = 1'b0; #1;
        chk("beq_z0", {7'b0, PCWrite}, 8'd0);
        funct3 = 3'b001; #1;
        chk("bne_z0", {7'b0, PCWrite}, 8'd1);
        Zero = 1'b1; #1;
        chk("bne_z1", {7'b0, PCWrite}, 8'd0);
        funct3 = 3'b100; Zero = 1'b0; #1;
        chk("blt_none", {7'b0, PCWrite}, 8'd0);
        chk("br_other_en", en(), 8'b0000);
        step();
        chk("br_done", {4'b0, state}, 8'd0);

        // R-type sub plus funct3 sweep in EXECR
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        step();
        step();
        chk("r_state", {4'b0, state}, 8'd6);
        chk("r_sub", {5'b0, ALUControl}, 8'b001);
        chk("r_srcb", {6'b0, ALUSrcB}, 8'b00);
        funct3 = 3'b111; #1;
        chk("r_and", {5'b0, ALUControl}, 8'b010);
        funct3 = 3'b110; #1;
        chk("r_or", {5'b0, ALUControl}, 8'b011);
        funct3 = 3'b010; #1;
        chk("r_slt", {5'b0, ALUControl}, 8'b101);
        funct3 = 3'b001; #1;
        chk("r_other", {5'b0, ALUControl}, 8'b000);
        step();
        chk("r_wb_state", {4'b0, state}, 8'd8);
        chk("r_wb_en", en(), 8'b0001);
        step();

        // addi with funct7b5=1 stays add
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        step();
        step();
        chk("i_state", {4'b0, state}, 8'd7);
        chk("i_add", {5'b0, ALUControl}, 8'b000);
        chk("i_srcb", {6'b0, ALUSrcB}, 8'b01);
        step();
        step();
        chk("i_done", {4'b0, state}, 8'd0);

        // jal
        op = 7'b1101111; funct7b5 = 1'b0;
        step();
        step();
        chk("jal_state", {4'b0, state}, 8'd10);
        chk("jal_en", en(), 8'b1000);
        chk("jal_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b0110);
        chk("jal_imm", {5'b0, ImmSrc}, 8'b011);
        step();
        chk("jal_wb", en(), 8'b0001);
        step();

        // lui
        op = 7'b0110111;
        step();
        step();
        chk("lui_state", {4'b0, state}, 8'd11);
        chk("lui_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b1101);
        chk("lui_imm", {5'b0, ImmSrc}, 8'b100);
        step();
        chk("lui_wb", {4'b0, state}, 8'd8);
        step();

        // Illegal opcode traps and holds
        op = 7'b1111111;
        step();
        chk("ill_decode", {7'b0, illegal}, 8'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            chk("trap_state", {4'b0, state}, 8'd12);
            chk("trap_illegal", {7'b0, illegal}, 8'd1);
            chk("trap_en", en(), 8'b0000);
            step();
        end
        resetn = 1'b1;
        step();
        chk("trap_rst_state", {4'b0, state}, 8'd0);
        chk("trap_rst_illegal", {7'b0, illegal}, 8'd0);
        resetn = 1'b0; #1;
        chk("trap_rel_en", en(), 8'b1010);

        // Reset in MEMWRITE aborts the store
        op = 7'b0100011;
        step();
        step();
        step();
        chk("abort_pre", en(), 8'b0100);
        resetn = 1'b1; #1;
        chk("abort_memwrite", {7'b0, MemWrite}, 8'd0);
        step();
        resetn = 1'b0; #1;
        chk("abort_state", {4'b0, state}, 8'd0);
        chk("abort_fetch_en", en(), 8'b1010);
        step();
        chk("abort_next", {4'b0, state}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: none; all encodings come from the shared package.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-high (1 = reset), sampled on rising clk.
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag, combinational from the datapath.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
REQ-010 MemWrite  out  1  memory write enable.
REQ-011 IRWrite  out  1  instruction register and OldPC enable.
REQ-012 ResultSrc  out  2  Result select: 00 = ALUOut, 01 = data, 10 = ALUResult.
REQ-013 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 ALUSrcA  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = register A, 11 = zero.
REQ-015 ALUSrcB  out  2  SrcB select: 00 = WriteData, 01 = ImmExt, 10 = constant 4.
REQ-016 ImmSrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-017 RegWrite  out  1  register file write enable.
REQ-018 state  out  4  current FSM state code, for debug.
REQ-019 illegal  out  1  sticky flag, set when an unsupported opcode is decoded.

Function
REQ-020 The block SHALL be a Moore FSM with registered state and combinational outputs decoded from state, plus the qualified PCWrite term.
REQ-021 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP.
REQ-022 FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-023 DECODE: SrcA=01, SrcB=01, add (branch target into ALUOut). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 -> LUI
- any other opcode -> TRAP
REQ-024 MEMADR: SrcA=10, SrcB=01, add; next state MEMREAD if op=0000011, MEMWRITE if op=0100011.
REQ-025 MEMREAD: ResultSrc=00, AdrSrc=1; next state MEMWB.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-027 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next state FETCH.
REQ-028 EXECR: SrcA=10, SrcB=00, function decode; next state ALUWB.
REQ-029 EXECI: SrcA=10, SrcB=01, function decode; next state ALUWB.
REQ-030 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-031 BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite SHALL be Zero for funct3=000 (beq), ~Zero for 001 (bne), and 0 for any other funct3. Next state FETCH.
REQ-032 JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1; next state ALUWB, which writes OldPC+4.
REQ-033 LUI: SrcA=11, SrcB=01, add; next state ALUWB.
REQ-034 TRAP: all enables 0, illegal=1; state held until reset.
REQ-035 Function decode, funct3:
- 000 -> sub if funct7b5=1 and op[5]=1, else add
- 010 -> slt
- 110 -> or
- 111 -> and
- others -> add
REQ-036 ImmSrc by op: 0100011 -> S, 1100011 -> B, 1101111 -> J, 0110111 -> U, else I; valid in every state.
REQ-037 In every state, any enable not listed for it (PCWrite, MemWrite, IRWrite, RegWrite) SHALL be 0.
REQ-038 Instruction latencies in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, lui 4.

Reset
REQ-039 While resetn=1 at a rising clk, the next state SHALL be FETCH and illegal SHALL be 0.
REQ-040 During reset, MemWrite, RegWrite, PCWrite and IRWrite SHALL be forced to 0.
REQ-041 Reset asserted mid-instruction SHALL abort that instruction with no further write; the first cycle after release is FETCH.

Structure
REQ-042 A shared package SHALL hold:
- state enum
- opcode constants
- ALUControl, ALUSrcA/B, ResultSrc and ImmSrc encodings
REQ-043 Sub-module alu_decoder SHALL implement REQ-035 (inputs: ALUOp class, funct3, funct7b5, op[5]).

Verification
REQ-044 Reset, then lw x1,4(x0) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01.
REQ-045 sw -> MemWrite=1 only in cycle 4, AdrSrc=1; no RegWrite.
REQ-046 beq with Zero=1 -> PCWrite=1 in BRANCH; with Zero=0 -> PCWrite=0; bne -> inverse.
REQ-047 sub (funct3=000, funct7b5=1, op=0110011) -> ALUControl=001; addi with funct7b5=1 -> ALUControl=000.
REQ-048 op=1111111 -> TRAP, illegal=1, no enables for 20 cycles; reset then returns to FETCH with illegal=0.
REQ-049 Reset asserted in MEMWRITE -> MemWrite=0 in the same cycle; FETCH follows the release of reset.
